// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I decode constants, ALU and result-select encodings,
// and the ID/EX pipeline bundle used by the decode stage.
package rv_pkg;

    localparam int DATA_W = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_JALR = 3'b000;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLL    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_SLT    = 4'd8,
        ALU_SLTU   = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef struct packed {
        logic              reg_write;
        logic              mem_write;
        logic              alu_src;
        result_src_e       result_src;
        alu_op_e           alu_control;
        logic              illegal;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm_ext;
        logic [DATA_W-1:0] pc_plus4;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
    } idex_t;

    // Maps funct3 (plus instr[30]) to an ALU operation; SUB only exists for register ops.
    function automatic alu_op_e alu_decode(input logic [2:0] funct3,
                                           input logic       alt,
                                           input logic       is_reg_op);
        alu_op_e op;
        case (funct3)
            3'b000:  op = (alt && is_reg_op) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen: extracts and sign-extends the immediate of an RV32I instruction,
// choosing the I, S, B, J or U layout from the opcode.
module imm_gen
    import rv_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    // Select the immediate layout by opcode; anything unrecognised uses the I layout.
    always_comb begin
        imm = '0;
        case (instr[6:0])
            OP_LUI, OP_AUIPC:
                imm = {instr[31:12], 12'b0};
            OP_JAL:
                imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            OP_BRANCH:
                imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            default:
                imm = {{20{instr[31]}}, instr[31:20]};
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with branch/jump resolution in decode, the
// fetch redirect outputs, one-instruction wrong-path squash and the ID/EX register.
// Optional feature: define DECODE_PERF_EN to add the DecCountD/RedirCountD counters.
module decode_stage
    import rv_pkg::*;
#(
    parameter int XLEN = DATA_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic            StallD,
    input  logic            FlushE,
    output logic [4:0]      Rs1D,
    output logic [4:0]      Rs2D,
    output logic            PCSrcD,
    output logic            JalD,
    output logic [XLEN-1:0] PCTargetD,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            ALUSrcE,
    output logic [1:0]      ResultSrcE,
    output logic [3:0]      ALUControlE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [4:0]      RdE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic            IllegalE
`ifdef DECODE_PERF_EN
    ,
    output logic [31:0]     DecCountD,
    output logic [31:0]     RedirCountD
`endif
);

    typedef enum logic {
        IDLE   = 1'b0,
        SQUASH = 1'b1
    } squash_e;

    squash_e     state;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic        reg_write;
    logic        mem_write;
    logic        alu_src;
    result_src_e result_src;
    alu_op_e     alu_control;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        is_auipc;
    logic        illegal;
    logic        taken;
    logic        squashing;
    logic        valid;
    logic        redirect;
    logic        kill;
    idex_t       dec;
    idex_t       nxt;
    idex_t       ex_q;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign Rs1D   = InstrD[19:15];
    assign Rs2D   = InstrD[24:20];

    imm_gen u_imm_gen (
        .instr (InstrD),
        .imm   (imm)
    );

    // Control decoder: unsupported opcodes or funct3 values leave every control bit at 0.
    always_comb begin
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        alu_src     = 1'b0;
        result_src  = RES_ALU;
        alu_control = ALU_ADD;
        is_branch   = 1'b0;
        is_jal      = 1'b0;
        is_jalr     = 1'b0;
        is_auipc    = 1'b0;
        illegal     = 1'b0;
        case (opcode)
            OP_LUI: begin
                reg_write   = 1'b1;
                alu_src     = 1'b1;
                alu_control = ALU_PASS_B;
            end
            OP_AUIPC: begin
                reg_write   = 1'b1;
                alu_src     = 1'b1;
                alu_control = ALU_PASS_B;
                is_auipc    = 1'b1;
            end
            OP_JAL: begin
                reg_write  = 1'b1;
                result_src = RES_PC4;
                is_jal     = 1'b1;
            end
            OP_JALR: begin
                if (funct3 == F3_JALR) begin
                    reg_write  = 1'b1;
                    alu_src    = 1'b1;
                    result_src = RES_PC4;
                    is_jalr    = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    illegal = 1'b1;
                end else begin
                    is_branch   = 1'b1;
                    alu_control = ALU_SUB;
                end
            end
            OP_LOAD: begin
                if (funct3 == F3_WORD) begin
                    reg_write  = 1'b1;
                    alu_src    = 1'b1;
                    result_src = RES_MEM;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_STORE: begin
                if (funct3 == F3_WORD) begin
                    mem_write = 1'b1;
                    alu_src   = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_IMM: begin
                reg_write   = 1'b1;
                alu_src     = 1'b1;
                alu_control = alu_decode(funct3, InstrD[30], 1'b0);
            end
            OP_OP: begin
                reg_write   = 1'b1;
                alu_control = alu_decode(funct3, InstrD[30], 1'b1);
            end
            default: illegal = 1'b1;
        endcase
    end

    // Branch comparator on the already-forwarded register operands.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (RD1D == RD2D);
            F3_BNE:  taken = (RD1D != RD2D);
            F3_BLT:  taken = ($signed(RD1D) < $signed(RD2D));
            F3_BGE:  taken = ($signed(RD1D) >= $signed(RD2D));
            F3_BLTU: taken = (RD1D < RD2D);
            F3_BGEU: taken = (RD1D >= RD2D);
            default: taken = 1'b0;
        endcase
    end

    // A stalled or squashed instruction must never steer fetch; reset also silences redirects.
    assign squashing = (state == SQUASH);
    assign valid     = !StallD && !squashing;
    assign PCSrcD    = rst && valid && is_branch && taken;
    assign JalD      = rst && valid && (is_jal || is_jalr);
    assign redirect  = PCSrcD || JalD;
    assign PCTargetD = is_jalr ? ((RD1D + imm) & ~XLEN'(1)) : (PCD + imm);

    // Squash tracker: after a redirect, the next unstalled instruction in D is wrong-path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (redirect) state <= SQUASH;
                SQUASH:  if (!StallD)  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Assemble the decoded bundle; data fields always carry decoded values.
    always_comb begin
        dec             = '0;
        dec.reg_write   = reg_write;
        dec.mem_write   = mem_write;
        dec.alu_src     = alu_src;
        dec.result_src  = result_src;
        dec.alu_control = alu_control;
        dec.illegal     = illegal;
        dec.rd1         = RD1D;
        dec.rd2         = RD2D;
        dec.imm_ext     = is_auipc ? (PCD + imm) : imm;
        dec.pc_plus4    = PCPlus4D;
        dec.rd          = InstrD[11:7];
        dec.rs1         = InstrD[19:15];
        dec.rs2         = InstrD[24:20];
    end

    // Bubble the control fields; an illegal flag survives only if nothing else killed the slot.
    assign kill = FlushE || StallD || squashing;

    always_comb begin
        nxt = dec;
        if (kill || illegal) begin
            nxt.reg_write   = 1'b0;
            nxt.mem_write   = 1'b0;
            nxt.alu_src     = 1'b0;
            nxt.result_src  = RES_ALU;
            nxt.alu_control = ALU_ADD;
            nxt.illegal     = illegal && !kill;
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= nxt;
        end
    end

    assign RegWriteE   = ex_q.reg_write;
    assign MemWriteE   = ex_q.mem_write;
    assign ALUSrcE     = ex_q.alu_src;
    assign ResultSrcE  = ex_q.result_src;
    assign ALUControlE = ex_q.alu_control;
    assign IllegalE    = ex_q.illegal;
    assign RD1E        = ex_q.rd1;
    assign RD2E        = ex_q.rd2;
    assign ImmExtE     = ex_q.imm_ext;
    assign PCPlus4E    = ex_q.pc_plus4;
    assign RdE         = ex_q.rd;
    assign Rs1E        = ex_q.rs1;
    assign Rs2E        = ex_q.rs2;

`ifdef DECODE_PERF_EN
    // Event counters: decoded (valid, legal) instructions and issued redirects.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            DecCountD   <= '0;
            RedirCountD <= '0;
        end else begin
            if (valid && !illegal) DecCountD <= DecCountD + 32'd1;
            if (redirect)          RedirCountD <= RedirCountD + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scenarios plus randomized instruction streams for
// decode_stage, checked against an ISA-level reference model.
// Compile with DECODE_PERF_EN to also check the event counters.
module tb_decode_stage;
    import rv_pkg::*;

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_BEQ  = 32'h02208063;
    localparam logic [31:0] I_BNE  = 32'h02209063;
    localparam logic [31:0] I_JALR = 32'h004280E7;
    localparam logic [31:0] I_JAL  = 32'h040000EF;
    localparam logic [31:0] I_BAD  = 32'h0000007F;

    logic        clk;
    logic        rst;
    logic [31:0] InstrD, PCD, PCPlus4D, RD1D, RD2D;
    logic        StallD, FlushE;
    logic [4:0]  Rs1D, Rs2D;
    logic        PCSrcD, JalD;
    logic [31:0] PCTargetD;
    logic        RegWriteE, MemWriteE, ALUSrcE, IllegalE;
    logic [1:0]  ResultSrcE;
    logic [3:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCPlus4E;
    logic [4:0]  RdE, Rs1E, Rs2E;
`ifdef DECODE_PERF_EN
    logic [31:0] DecCountD, RedirCountD;
`endif

    int checks = 0;
    int errors = 0;

    // Reference-model state and expectations.
    logic        m_squash, nxt_squash, nxt_dec, nxt_redir;
    logic [31:0] m_dec, m_redir;
    logic        x_pcsrc, x_jal, x_rw, x_mw, x_asrc, x_ill, x_imm_known;
    logic [31:0] x_target, x_imm, x_rd1, x_rd2, x_pc4;
    logic [1:0]  x_rsrc;
    logic [3:0]  x_aluc;
    logic [4:0]  x_rd, x_rs1, x_rs2;

    typedef struct packed {
        logic        illegal;
        logic        known;
        logic        taken;
        logic        jump;
        logic [31:0] target;
        logic        rw;
        logic        mw;
        logic        asrc;
        logic [1:0]  rsrc;
        logic [3:0]  aluc;
        logic [31:0] imme;
    } ref_t;

    decode_stage dut (
        .clk         (clk),
        .rst         (rst),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .RD1D        (RD1D),
        .RD2D        (RD2D),
        .StallD      (StallD),
        .FlushE      (FlushE),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .PCSrcD      (PCSrcD),
        .JalD        (JalD),
        .PCTargetD   (PCTargetD),
        .RegWriteE   (RegWriteE),
        .MemWriteE   (MemWriteE),
        .ALUSrcE     (ALUSrcE),
        .ResultSrcE  (ResultSrcE),
        .ALUControlE (ALUControlE),
        .RD1E        (RD1E),
        .RD2E        (RD2E),
        .ImmExtE     (ImmExtE),
        .PCPlus4E    (PCPlus4E),
        .RdE         (RdE),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .IllegalE    (IllegalE)
`ifdef DECODE_PERF_EN
        ,
        .DecCountD   (DecCountD),
        .RedirCountD (RedirCountD)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ISA-level meaning of an instruction: immediates by arithmetic, control by mnemonic.
    function automatic logic [3:0] isa_alu(input logic [2:0] f3, input logic b30, input logic regop);
        logic [3:0] r;
        case (f3)
            3'd0:    r = (regop && b30) ? ALU_SUB : ALU_ADD;
            3'd1:    r = ALU_SLL;
            3'd2:    r = ALU_SLT;
            3'd3:    r = ALU_SLTU;
            3'd4:    r = ALU_XOR;
            3'd5:    r = b30 ? ALU_SRA : ALU_SRL;
            3'd6:    r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

    function automatic ref_t ref_decode(input logic [31:0] i, input logic [31:0] pc,
                                        input logic [31:0] a, input logic [31:0] b);
        ref_t r;
        logic [31:0] si, ss, sb, sj, su;
        logic [2:0]  f3;
        f3 = i[14:12];
        si = 32'($signed(i) >>> 20);
        ss = (32'($signed(i) >>> 25) << 5) | 32'(i[11:7]);
        sb = (32'($signed(i) >>> 31) << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
        sj = (32'($signed(i) >>> 31) << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
        su = i & 32'hFFFFF000;
        r = '0;
        r.known = 1'b1;
        r.aluc = ALU_ADD;
        case (i[6:0])
            7'h37: begin r.rw = 1; r.asrc = 1; r.aluc = ALU_PASS_B; r.imme = su; end
            7'h17: begin r.rw = 1; r.asrc = 1; r.aluc = ALU_PASS_B; r.imme = pc + su; end
            7'h6F: begin r.rw = 1; r.rsrc = 2'b10; r.jump = 1; r.target = pc + sj; r.imme = sj; end
            7'h67: begin
                r.imme = si;
                if (f3 == 3'd0) begin
                    r.rw = 1; r.asrc = 1; r.rsrc = 2'b10; r.jump = 1;
                    r.target = (a + si) & 32'hFFFFFFFE;
                end else r.illegal = 1;
            end
            7'h63: begin
                r.imme = sb;
                r.target = pc + sb;
                if (f3 == 3'd2 || f3 == 3'd3) r.illegal = 1;
                else begin
                    r.aluc = ALU_SUB;
                    case (f3)
                        3'd0:    r.taken = (a == b);
                        3'd1:    r.taken = (a != b);
                        3'd4:    r.taken = ($signed(a) < $signed(b));
                        3'd5:    r.taken = !($signed(a) < $signed(b));
                        3'd6:    r.taken = (a < b);
                        default: r.taken = !(a < b);
                    endcase
                end
            end
            7'h03: begin
                r.imme = si;
                if (f3 == 3'd2) begin r.rw = 1; r.asrc = 1; r.rsrc = 2'b01; end
                else r.illegal = 1;
            end
            7'h23: begin
                r.imme = ss;
                if (f3 == 3'd2) begin r.mw = 1; r.asrc = 1; end
                else r.illegal = 1;
            end
            7'h13: begin r.imme = si; r.rw = 1; r.asrc = 1; r.aluc = isa_alu(f3, i[30], 1'b0); end
            7'h33: begin r.imme = si; r.rw = 1; r.aluc = isa_alu(f3, i[30], 1'b1); end
            default: begin r.illegal = 1; r.known = 0; end
        endcase
        return r;
    endfunction

    // Drive one D-stage instruction and compute what decode should do with it.
    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic stall, input logic flush);
        ref_t r;
        logic v, kill;
        InstrD = instr; PCD = pc; PCPlus4D = pc + 32'd4;
        RD1D = a; RD2D = b; StallD = stall; FlushE = flush;
        r = ref_decode(instr, pc, a, b);
        v = !stall && !m_squash;
        x_pcsrc = v && r.taken;
        x_jal = v && r.jump;
        x_target = r.target;
        kill = flush || stall || m_squash;
        if (kill || r.illegal) begin
            x_rw = 0; x_mw = 0; x_asrc = 0; x_rsrc = 2'b00; x_aluc = 4'd0;
        end else begin
            x_rw = r.rw; x_mw = r.mw; x_asrc = r.asrc; x_rsrc = r.rsrc; x_aluc = r.aluc;
        end
        x_ill = r.illegal && !kill;
        x_imm = r.imme; x_imm_known = r.known;
        x_rd1 = a; x_rd2 = b; x_pc4 = pc + 32'd4;
        x_rd = instr[11:7]; x_rs1 = instr[19:15]; x_rs2 = instr[24:20];
        nxt_squash = m_squash ? stall : (x_pcsrc || x_jal);
        nxt_dec = v && !r.illegal;
        nxt_redir = x_pcsrc || x_jal;
        #2;
    endtask

    task automatic clockEdge();
        @(posedge clk);
        m_squash = nxt_squash;
        if (nxt_dec) m_dec = m_dec + 32'd1;
        if (nxt_redir) m_redir = m_redir + 32'd1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        m_squash = 0; m_dec = 0; m_redir = 0;
        InstrD = I_ADDI; PCD = 32'h0; PCPlus4D = 32'h4; RD1D = 32'h11; RD2D = 32'h22;
        StallD = 0; FlushE = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({RegWriteE, MemWriteE, ALUSrcE, IllegalE, ResultSrcE, ALUControlE} !== 10'd0) begin
            errors++; $display("[TB] FAIL reset_ctrl got %0h want 0", {RegWriteE, MemWriteE, ALUSrcE, IllegalE, ResultSrcE, ALUControlE});
        end
        checks++;
        if ({RD1E, RD2E, ImmExtE, PCPlus4E, RdE, Rs1E, Rs2E} !== 143'd0) begin
            errors++; $display("[TB] FAIL reset_data got imm %0h rd %0d want 0", ImmExtE, RdE);
        end
        InstrD = I_JAL;
        #1;
        checks++;
        if ({PCSrcD, JalD} !== 2'b00) begin
            errors++; $display("[TB] FAIL reset_redirect got %b want 00", {PCSrcD, JalD});
        end
`ifdef DECODE_PERF_EN
        checks++;
        if ({DecCountD, RedirCountD} !== 64'd0) begin
            errors++; $display("[TB] FAIL reset_counters got %0h %0h want 0", DecCountD, RedirCountD);
        end
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(I_ADDI, 32'h0, 32'h0, 32'h0, 0, 0);
        clockEdge();
        checks++;
        if ({RegWriteE, ALUSrcE, RdE, ImmExtE} !== {1'b1, 1'b1, 5'd1, 32'd5}) begin
            errors++; $display("[TB] FAIL addi_first got rw %b src %b rd %0d imm %0h want 1 1 1 5", RegWriteE, ALUSrcE, RdE, ImmExtE);
        end
    endtask

    task automatic test_beq_squash();
        applyStimulus(I_BEQ, 32'h100, 32'd7, 32'd7, 0, 0);
        checks++;
        if ({PCSrcD, JalD, PCTargetD} !== {1'b1, 1'b0, 32'h120}) begin
            errors++; $display("[TB] FAIL beq_taken got %b%b %0h want 10 120", PCSrcD, JalD, PCTargetD);
        end
        clockEdge();
        applyStimulus(I_JAL, 32'h104, 32'd1, 32'd2, 0, 0);
        checks++;
        if (JalD !== 1'b0) begin
            errors++; $display("[TB] FAIL squash_noredirect got %b want 0", JalD);
        end
        clockEdge();
        checks++;
        if ({RegWriteE, ResultSrcE} !== 3'b000) begin
            errors++; $display("[TB] FAIL squash_bubble got %b want 000", {RegWriteE, ResultSrcE});
        end
        applyStimulus(I_ADDI, 32'h120, 32'd0, 32'd0, 0, 0);
        clockEdge();
        checks++;
        if ({RegWriteE, ImmExtE} !== {1'b1, 32'd5}) begin
            errors++; $display("[TB] FAIL after_squash got %b %0h want 1 5", RegWriteE, ImmExtE);
        end
    endtask

    task automatic test_bne_equal();
        applyStimulus(I_BNE, 32'h200, 32'd9, 32'd9, 0, 0);
        checks++;
        if (PCSrcD !== 1'b0) begin
            errors++; $display("[TB] FAIL bne_equal got %b want 0", PCSrcD);
        end
        clockEdge();
        applyStimulus(I_ADDI, 32'h204, 32'd0, 32'd0, 0, 0);
        clockEdge();
        checks++;
        if (RegWriteE !== 1'b1) begin
            errors++; $display("[TB] FAIL bne_nosquash got %b want 1", RegWriteE);
        end
    endtask

    task automatic test_jalr();
        applyStimulus(I_JALR, 32'h300, 32'h203, 32'h0, 0, 0);
        checks++;
        if ({JalD, PCTargetD} !== {1'b1, 32'h206}) begin
            errors++; $display("[TB] FAIL jalr_target got %b %0h want 1 206", JalD, PCTargetD);
        end
        clockEdge();
        checks++;
        if ({ResultSrcE, RegWriteE, RdE} !== {2'b10, 1'b1, 5'd1}) begin
            errors++; $display("[TB] FAIL jalr_e got %b %b %0d want 10 1 1", ResultSrcE, RegWriteE, RdE);
        end
        applyStimulus(I_ADDI, 32'h304, 32'd0, 32'd0, 0, 0);
        clockEdge();
    endtask

    task automatic test_jal_stall();
        for (int c = 0; c < 2; c++) begin
            applyStimulus(I_JAL, 32'h400, 32'd0, 32'd0, 1, 0);
            checks++;
            if (JalD !== 1'b0) begin
                errors++; $display("[TB] FAIL jal_stalled cycle %0d got %b want 0", c, JalD);
            end
            clockEdge();
            checks++;
            if (RegWriteE !== 1'b0) begin
                errors++; $display("[TB] FAIL jal_stall_bubble cycle %0d got %b want 0", c, RegWriteE);
            end
        end
        applyStimulus(I_JAL, 32'h400, 32'd0, 32'd0, 0, 0);
        checks++;
        if ({JalD, PCTargetD} !== {1'b1, 32'h440}) begin
            errors++; $display("[TB] FAIL jal_release got %b %0h want 1 440", JalD, PCTargetD);
        end
        clockEdge();
        checks++;
        if ({RegWriteE, ResultSrcE} !== 3'b110) begin
            errors++; $display("[TB] FAIL jal_e got %b want 110", {RegWriteE, ResultSrcE});
        end
        applyStimulus(I_ADDI, 32'h404, 32'd0, 32'd0, 0, 0);
        clockEdge();
    endtask

    task automatic test_flush_redirect();
        applyStimulus(I_JAL, 32'h500, 32'd0, 32'd0, 0, 1);
        checks++;
        if (JalD !== 1'b1) begin
            errors++; $display("[TB] FAIL flush_redirect got %b want 1", JalD);
        end
        clockEdge();
        checks++;
        if (RegWriteE !== 1'b0) begin
            errors++; $display("[TB] FAIL flush_bubble got %b want 0", RegWriteE);
        end
        applyStimulus(I_JAL, 32'h504, 32'd0, 32'd0, 0, 0);
        checks++;
        if (JalD !== 1'b0) begin
            errors++; $display("[TB] FAIL flush_squash got %b want 0", JalD);
        end
        clockEdge();
    endtask

    task automatic test_illegal();
`ifdef DECODE_PERF_EN
        logic [31:0] before;
        before = DecCountD;
`endif
        applyStimulus(I_BAD, 32'h600, 32'd0, 32'd0, 0, 0);
        checks++;
        if ({PCSrcD, JalD} !== 2'b00) begin
            errors++; $display("[TB] FAIL illegal_redirect got %b want 00", {PCSrcD, JalD});
        end
        clockEdge();
        checks++;
        if ({IllegalE, RegWriteE, MemWriteE} !== 3'b100) begin
            errors++; $display("[TB] FAIL illegal_e got %b want 100", {IllegalE, RegWriteE, MemWriteE});
        end
`ifdef DECODE_PERF_EN
        checks++;
        if (DecCountD !== before) begin
            errors++; $display("[TB] FAIL illegal_count got %0d want %0d", DecCountD, before);
        end
`endif
    endtask

    task automatic test_async_reset();
        applyStimulus(I_ADDI, 32'h700, 32'd0, 32'd0, 0, 0);
        clockEdge();
        applyStimulus(I_JAL, 32'h704, 32'd0, 32'd0, 0, 0);
        rst = 1'b0;
        #1;
        checks++;
        if ({RegWriteE, ImmExtE, JalD} !== 34'd0) begin
            errors++; $display("[TB] FAIL async_reset got rw %b imm %0h jal %b want 0", RegWriteE, ImmExtE, JalD);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_squash = 0; m_dec = 0; m_redir = 0;
        applyStimulus(I_JAL, 32'h708, 32'd0, 32'd0, 0, 0);
        checks++;
        if (JalD !== 1'b1) begin
            errors++; $display("[TB] FAIL post_reset_idle got %b want 1", JalD);
        end
        clockEdge();
        applyStimulus(I_ADDI, 32'h70C, 32'd0, 32'd0, 0, 0);
        clockEdge();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic [31:0] instr, a, b, pc;
            logic        st, fl;
            int          k;
            instr = $urandom;
            a = $urandom;
            b = ($urandom_range(0, 1) == 1) ? a : $urandom;
            pc = $urandom & 32'hFFFFFFFC;
            st = ($urandom_range(0, 4) == 0);
            fl = ($urandom_range(0, 7) == 0);
            k = $urandom_range(0, 9);
            case (k)
                0: instr[6:0] = OP_LUI;
                1: instr[6:0] = OP_AUIPC;
                2: instr[6:0] = OP_JAL;
                3: instr[6:0] = OP_JALR;
                4: instr[6:0] = OP_BRANCH;
                5: instr[6:0] = OP_LOAD;
                6: instr[6:0] = OP_STORE;
                7: instr[6:0] = OP_IMM;
                8: instr[6:0] = OP_OP;
                default: instr[6:0] = 7'($urandom);
            endcase
            if (k == 3 && $urandom_range(0, 3) != 0) instr[14:12] = 3'b000;
            if ((k == 5 || k == 6) && $urandom_range(0, 3) != 0) instr[14:12] = 3'b010;
            applyStimulus(instr, pc, a, b, st, fl);
            checks++;
            if ({PCSrcD, JalD, Rs1D, Rs2D} !== {x_pcsrc, x_jal, x_rs1, x_rs2}) begin
                errors++; $display("[TB] FAIL rnd_comb n=%0d instr %h got %b%b want %b%b", n, instr, PCSrcD, JalD, x_pcsrc, x_jal);
            end
            if (x_pcsrc || x_jal) begin
                checks++;
                if (PCTargetD !== x_target) begin
                    errors++; $display("[TB] FAIL rnd_target n=%0d instr %h got %h want %h", n, instr, PCTargetD, x_target);
                end
            end
            clockEdge();
            checks++;
            if ({RegWriteE, MemWriteE, ALUSrcE, ResultSrcE, ALUControlE, IllegalE} !==
                {x_rw, x_mw, x_asrc, x_rsrc, x_aluc, x_ill}) begin
                errors++; $display("[TB] FAIL rnd_ctrl n=%0d instr %h got %b want %b", n, instr,
                    {RegWriteE, MemWriteE, ALUSrcE, ResultSrcE, ALUControlE, IllegalE},
                    {x_rw, x_mw, x_asrc, x_rsrc, x_aluc, x_ill});
            end
            checks++;
            if ({RD1E, RD2E, PCPlus4E, RdE, Rs1E, Rs2E} !== {x_rd1, x_rd2, x_pc4, x_rd, x_rs1, x_rs2}) begin
                errors++; $display("[TB] FAIL rnd_data n=%0d instr %h got %h %h %h want %h %h %h", n, instr, RD1E, RD2E, PCPlus4E, x_rd1, x_rd2, x_pc4);
            end
            if (x_imm_known) begin
                checks++;
                if (ImmExtE !== x_imm) begin
                    errors++; $display("[TB] FAIL rnd_imm n=%0d instr %h got %h want %h", n, instr, ImmExtE, x_imm);
                end
            end
        end
`ifdef DECODE_PERF_EN
        checks++;
        if ({DecCountD, RedirCountD} !== {m_dec, m_redir}) begin
            errors++; $display("[TB] FAIL rnd_counters got %0d %0d want %0d %0d", DecCountD, RedirCountD, m_dec, m_redir);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_beq_squash();
        test_bne_equal();
        test_jalr();
        test_jal_stall();
        test_flush_redirect();
        test_illegal();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Pipeline decode stage and the consuming end of the fetch redirect interface. Takes the fetched instruction, PC and PC+4 from the IF/ID register. Decodes the RV32I base subset, resolves branches and jumps in decode, and drives `PCSrcD`, `JalD` and `PCTargetD` back to `fetch_stage`. Registers the decoded control and operands into the ID/EX pipeline register. Squashes the single wrong-path instruction that follows every redirect.

## Interface
- `XLEN`, 32: datapath width
- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `InstrD` in 32: instruction from the IF/ID register
- `PCD` in 32: PC of `InstrD`
- `PCPlus4D` in 32: `PCD`+4
- `RD1D`, `RD2D` in 32 each: register-file read data for rs1/rs2, already forwarded
- `StallD` in 1: hazard unit holds the IF/ID register
- `FlushE` in 1: hazard unit bubbles ID/EX
- `Rs1D`, `Rs2D` out 5 each: register-file read addresses, `InstrD[19:15]` and `InstrD[24:20]`
- `PCSrcD` out 1: conditional branch taken
- `JalD` out 1: JAL or JALR
- `PCTargetD` out 32: redirect target
- `RegWriteE`, `MemWriteE`, `ALUSrcE` out 1 each: registered control
- `ResultSrcE` out 2: 00 ALU, 01 memory, 10 PC+4
- `ALUControlE` out 4: registered ALU operation
- `RD1E`, `RD2E`, `ImmExtE`, `PCPlus4E` out 32 each: registered operands
- `RdE`, `Rs1E`, `Rs2E` out 5 each: registered register indices
- `IllegalE` out 1: registered illegal-opcode flag

## Operation
- Supported opcodes:
  - LUI 0110111
  - AUIPC 0010111
  - JAL 1101111
  - JALR 1100111
  - BRANCH 1100011, funct3 000/001/100/101/110/111
  - LOAD 0000011, LW only
  - STORE 0100011, SW only
  - OP-IMM 0010011
  - OP 0110011
- Any other opcode or funct3: `IllegalE`=1, all other control bits 0, no redirect.
- Immediates are sign-extended to 32 bits (I, S, B, J, U forms).
- Targets:
  - JAL and branches: `PCTargetD` = `PCD`+imm.
  - JALR: `PCTargetD` = (`RD1D`+imm) & ~1.
  - Adds are modulo 2^32; wrap-around is not an error.
- LUI/AUIPC result is computed in decode: `ImmExtE` = imm (LUI) or `PCD`+imm (AUIPC), with `ALUControlE`=PASS_B and `ALUSrcE`=1.
- Branch compare uses `RD1D`/`RD2D`: signed for BLT/BGE, unsigned for BLTU/BGEU.
- `valid` = !`StallD` && !`squash`. `PCSrcD` and `JalD` are gated by `valid`; `PCTargetD` is don't-care when both are 0.
- Redirect = `PCSrcD` | `JalD`.
- Squash state, one flop:
  - IDLE -> SQUASH on any clock edge where redirect = 1.
  - SQUASH -> IDLE on the next edge where `StallD` = 0.
  - In SQUASH, the instruction in D is a bubble: no redirect, no control into E.
  - A squashed branch never redirects, so SQUASH never chains.
- ID/EX register:
  - Loads a bubble when `FlushE`, `StallD`, `squash` or the illegal flag is set.
  - Bubble: all control bits and `IllegalE` = 0 except `IllegalE` for an illegal instruction; data fields hold decoded values.
  - Otherwise loads the decoded values.
  - Priority: reset > `FlushE` > `StallD` > `squash`.

## Timing
- Redirect outputs and `PCTargetD` are combinational from D inputs, same cycle, for fetch's next-PC mux.
- E outputs have 1-cycle latency.
- Reset values: squash = IDLE, all E outputs 0. Redirect outputs are 0 while in reset.
- Reset asserted mid-operation clears squash and E immediately, with no clock required.
- `StallD` and a redirect-qualifying instruction in the same cycle: redirect suppressed. The redirect is reissued on the first unstalled cycle with fresh `RD1D`/`RD2D`.
- `FlushE` together with a redirect: the redirect still fires, and E takes a bubble.

## Configuration
- `DECODE_PERF_EN` defined:
  - Adds output `DecCountD` (32) and output `RedirCountD` (32).
  - `DecCountD` increments once per valid, non-illegal instruction.
  - `RedirCountD` increments once per redirect.
  - Both wrap modulo 2^32 and reset to 0.
- `DECODE_PERF_EN` undefined: no counters, no ports.

## Structure
- Shared package `rv_pkg` holds:
  - opcode constants
  - `ALUControl` encodings: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, PASS_B
  - `ResultSrc` encodings
  - the ID/EX bundle typedef
- One sub-module, `imm_gen`: combinational, takes the instruction and returns the sign-extended immediate.
- The top level holds the control decoder, branch comparator, squash flop, ID/EX register and counters.

## Test plan
- Reset low with `InstrD`=0x00500093 (ADDI x1,x0,5): all E outputs stay 0. After reset, one edge gives `RegWriteE`=1, `ImmExtE`=5, `RdE`=1, `ALUSrcE`=1.
- BEQ, `PCD`=0x100, imm=+0x20, `RD1D`=`RD2D`=7: `PCSrcD`=1 and `PCTargetD`=0x120 the same cycle. The next D instruction is squashed (E bubble). The instruction after that decodes normally.
- BNE with equal operands: `PCSrcD`=0 and no squash.
- JALR, `RD1D`=0x203, imm=4: `JalD`=1, `PCTargetD`=0x206. `ResultSrcE`=10.
- JAL with `StallD`=1 for 2 cycles: `JalD`=0 while stalled and E bubbles. `JalD`=1 on the first unstalled cycle.
- Opcode 0x7F: `IllegalE`=1 and no redirect. With `DECODE_PERF_EN`, `DecCountD` is unchanged.
